// File: rtl/snake_pace_gen.sv
// -----------------------------------------------------------------------------
// snake_pace_gen
//
// Game pace generator placed directly upstream of the game top.
// o_phase toggles once per move period, and each toggle lets the game
// advance the snake by one step. Each apple eaten shortens the period by
// PERIOD_STEP, down to a floor of PERIOD_MIN. A failure or success
// freezes the pace until rst is asserted.
//
// Optional feature: define PACE_PAUSE_EN to let a rising edge on i_pause
// toggle between RUN and PAUSED. If the macro is undefined, i_pause is
// ignored and stays only to keep the port list fixed.
//
// Ports:
//   clk        in   1   system clock (VGA pixel clock)
//   rst        in   1   synchronous, active-high reset (game restart / power-on)
//   i_eat      in   1   apple eaten; may stay high for several cycles
//   i_failure  in   1   game lost (level)
//   i_success  in   1   game won (level)
//   i_pause    in   1   pause button, already synchronised and debounced
//   o_phase    out  1   phase toggle to the game's i_phase
//   o_step     out  1   1-cycle pulse in the cycle o_phase toggles
//   o_level    out  4   apples eaten, saturating at 15
//   o_running  out  1   high while the pace is in RUN
// -----------------------------------------------------------------------------
module snake_pace_gen #(
    parameter int CNT_W       = 23,
    parameter int PERIOD_INIT = 6_250_000,
    parameter int PERIOD_MIN  = 1_562_500,
    parameter int PERIOD_STEP = 312_500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_eat,
    input  logic       i_failure,
    input  logic       i_success,
    input  logic       i_pause,
    output logic       o_phase,
    output logic       o_step,
    output logic [3:0] o_level,
    output logic       o_running
);

    localparam logic [CNT_W-1:0] P_INIT = CNT_W'(PERIOD_INIT);
    localparam logic [CNT_W-1:0] P_MIN  = CNT_W'(PERIOD_MIN);
    localparam logic [CNT_W-1:0] P_STEP = CNT_W'(PERIOD_STEP);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    // One bit wider than the counter, so PERIOD_MIN + PERIOD_STEP cannot wrap.
    localparam logic [CNT_W:0] SPEED_THRESH =
        (CNT_W+1)'(PERIOD_MIN) + (CNT_W+1)'(PERIOD_STEP);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  period;
    logic              eat_q;
    logic              eat_edge;
    logic              halt_req;

    assign eat_edge = i_eat & ~eat_q;
    assign halt_req = i_failure | i_success;

`ifdef PACE_PAUSE_EN
    logic pause_q;
    logic pause_edge;

    assign pause_edge = i_pause & ~pause_q;

    always_ff @(posedge clk) begin
        if (rst) pause_q <= 1'b0;
        else     pause_q <= i_pause;
    end
`else
    logic unused_pause;
    assign unused_pause = i_pause;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Next-state logic. A halt request outranks a pause edge, and HALTED is left only through rst.
    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        state_nxt = state;
        if (halt_req) begin
            state_nxt = HALTED;
        end
`ifdef PACE_PAUSE_EN
        else if (pause_edge) begin
            case (state)
                RUN:     state_nxt = PAUSED;
                PAUSED:  state_nxt = RUN;
                default: state_nxt = state;
            endcase
        end
`endif
    end

    // Output decode.
    always_comb begin
        o_running = (state == RUN);
    end

    // Period counter, phase toggle and speed-up datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_phase <= 1'b0;
            o_step  <= 1'b0;
            o_level <= 4'd0;
            period  <= P_INIT;
            count   <= P_INIT - ONE;
            eat_q   <= 1'b0;
        end else begin
            eat_q  <= i_eat;
            o_step <= 1'b0;

            // A halt arriving on the same edge as count==0 suppresses the toggle.
            if (state == RUN && !halt_req) begin
                if (count == '0) begin
                    o_phase <= ~o_phase;
                    o_step  <= 1'b1;
                    // NOTE: non-blocking assignment means this reload reads the period
                    // from before any speed-up on this same edge.
                    count   <= period - ONE;
                end else begin
                    count <= count - ONE;
                end
            end

            // Eat events are handled in every state. The running count is left
            // unchanged, so a new period applies only from the next reload.
            if (eat_edge) begin
                period  <= ({1'b0, period} >= SPEED_THRESH) ? (period - P_STEP) : P_MIN;
                o_level <= (o_level == 4'd15) ? 4'd15 : (o_level + 4'd1);
            end
        end
    end

endmodule

// File: tb/tb_snake_pace_gen.sv
// -----------------------------------------------------------------------------
// tb_snake_pace_gen
//
// Self-checking bench for snake_pace_gen, built with CNT_W=4, PERIOD_INIT=8,
// PERIOD_MIN=4 and PERIOD_STEP=3. A table of {inputs, cycles, expected outputs}
// records is applied in a loop. Hand-written sequences follow for level
// saturation and for the pause toggle. The pause sequence checks different
// results depending on whether PACE_PAUSE_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_snake_pace_gen;

    logic       clk;
    logic       rst;
    logic       i_eat;
    logic       i_failure;
    logic       i_success;
    logic       i_pause;
    logic       o_phase;
    logic       o_step;
    logic [3:0] o_level;
    logic       o_running;

    int errors = 0;
    int checks = 0;

    snake_pace_gen #(
        .CNT_W      (4),
        .PERIOD_INIT(8),
        .PERIOD_MIN (4),
        .PERIOD_STEP(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_eat    (i_eat),
        .i_failure(i_failure),
        .i_success(i_success),
        .i_pause  (i_pause),
        .o_phase  (o_phase),
        .o_step   (o_step),
        .o_level  (o_level),
        .o_running(o_running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       eat;
        logic       fail;
        logic       succ;
        int         n;      // clock edges the inputs are held for
        logic       phase;
        logic       step;
        logic [3:0] level;
        logic       run;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [6:0] actual, input logic [6:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got {phase,step,level,run}=%b, expected %b", name, actual, expected);
        end
    endtask

    // Drive inputs, then sample 1 ns after the next rising edge.
    task automatic tick(input logic r, input logic e, input logic f, input logic s, input logic p);
        rst       = r;
        i_eat     = e;
        i_failure = f;
        i_success = s;
        i_pause   = p;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] outs();
        return {o_phase, o_step, o_level, o_running};
    endfunction

    function automatic logic [6:0] exp(input logic ph, input logic st, input logic [3:0] lv, input logic rn);
        return {ph, st, lv, rn};
    endfunction

    initial begin
        // Edge numbers below are counted from the release of rst.
        //                rst eat fail succ  n  ph st lvl run
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 7, 1'b0,1'b0,4'd0,1'b1}); // edge 7: not yet
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 1, 1'b1,1'b1,4'd0,1'b1}); // edge 8: toggle
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 1, 1'b1,1'b0,4'd0,1'b1}); // step is one cycle
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 7, 1'b0,1'b1,4'd0,1'b1}); // edge 16
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 8, 1'b1,1'b1,4'd0,1'b1}); // edge 24
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0, 5, 1'b1,1'b0,4'd1,1'b1}); // eat held 5: level 1
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 3, 1'b0,1'b1,4'd1,1'b1}); // edge 32: in-flight 8
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4, 1'b0,1'b0,4'd1,1'b1}); // edge 36
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 1, 1'b1,1'b1,4'd1,1'b1}); // edge 37: period 5
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0, 1, 1'b1,1'b0,4'd2,1'b1}); // 2nd eat -> period 4
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4, 1'b0,1'b1,4'd2,1'b1}); // edge 42: old period 5
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4, 1'b1,1'b1,4'd2,1'b1}); // edge 46: period 4
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0, 1, 1'b1,1'b0,4'd3,1'b1}); // 3rd eat: floor holds
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 3, 1'b0,1'b1,4'd3,1'b1}); // edge 50
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4, 1'b1,1'b1,4'd3,1'b1}); // edge 54: still 4
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 3, 1'b1,1'b0,4'd3,1'b1}); // count==0 now
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0, 1, 1'b1,1'b0,4'd3,1'b0}); // failure beats toggle
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,10, 1'b1,1'b0,4'd3,1'b0}); // frozen while halted
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0, 1, 1'b1,1'b0,4'd4,1'b0}); // eat while halted
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 1, 1'b1,1'b0,4'd4,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0, 1, 1'b1,1'b0,4'd5,1'b0}); // level 5, halted
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0, 1, 1'b0,1'b0,4'd0,1'b1}); // rst from HALTED
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 7, 1'b0,1'b0,4'd0,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 1, 1'b1,1'b1,4'd0,1'b1}); // period back to 8
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 7, 1'b1,1'b0,4'd0,1'b1}); // count==0 now
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1, 1, 1'b1,1'b0,4'd0,1'b0}); // success beats toggle
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 9, 1'b1,1'b0,4'd0,1'b0}); // frozen
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0, 1, 1'b0,1'b0,4'd0,1'b1}); // rst

        // Power-on reset.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset", outs(), exp(1'b0, 1'b0, 4'd0, 1'b1));

        // Table-driven vectors.
        for (int v = 0; v < vecs.size(); v++) begin
            for (int c = 0; c < vecs[v].n; c++)
                tick(vecs[v].rst, vecs[v].eat, vecs[v].fail, vecs[v].succ, 1'b0);
            check($sformatf("vec%0d", v), outs(),
                  exp(vecs[v].phase, vecs[v].step, vecs[v].level, vecs[v].run));
        end

        // Level saturation: 20 separate eat edges. Phase is ignored here.
        for (int i = 1; i <= 20; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 14) check("level_14", {3'b000, o_level}, 7'd14);
            if (i == 15) check("level_15", {3'b000, o_level}, 7'd15);
        end
        check("level_sat_20", {3'b000, o_level}, 7'd15);

        // Pause sequence. Start from rst, so count=7 and period=8.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   // count = 3
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);              // edge 5: pause edge
`ifdef PACE_PAUSE_EN
        check("pause_enter", outs(), exp(1'b0, 1'b0, 4'd0, 1'b0));
`else
        check("pause_ignored", outs(), exp(1'b0, 1'b0, 4'd0, 1'b1));
`endif
        repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // edges 6..15
`ifdef PACE_PAUSE_EN
        check("pause_frozen", outs(), exp(1'b0, 1'b0, 4'd0, 1'b0));
`else
        check("no_pause_toggled", outs(), exp(1'b1, 1'b0, 4'd0, 1'b1));
`endif
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);              // edge 16: second pause edge
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);              // edge 17
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);              // edge 18
`ifdef PACE_PAUSE_EN
        check("resume_pre", outs(), exp(1'b0, 1'b0, 4'd0, 1'b1));
`else
        check("no_pause_pre", outs(), exp(1'b0, 1'b0, 4'd0, 1'b1));
`endif
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);              // edge 19
`ifdef PACE_PAUSE_EN
        check("resume_toggle", outs(), exp(1'b1, 1'b1, 4'd0, 1'b1));
`else
        check("no_pause_steady", outs(), exp(1'b0, 1'b0, 4'd0, 1'b1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
